// File: rtl/gray_window_3x3_if.sv
// Pixel stream in / 3x3 window stream out for gray_window_3x3.
// The master side drives the pixel stream; the slave side is the window generator.
interface gray_window_3x3_if #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int DW    = 12
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;

  logic          out_valid;
  logic          out_eof;
  logic [DW-1:0] data00_o, data01_o, data02_o;
  logic [DW-1:0] data10_o, data11_o, data12_o;
  logic [DW-1:0] data20_o, data21_o, data22_o;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_eof,
    input  data00_o, data01_o, data02_o,
    input  data10_o, data11_o, data12_o,
    input  data20_o, data21_o, data22_o,
    input  out_x, out_y
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_eof,
    output data00_o, data01_o, data02_o,
    output data10_o, data11_o, data12_o,
    output data20_o, data21_o, data22_o,
    output out_x, out_y
  );
endinterface

// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one window per accepted pixel whose centre is not on the frame border.
module gray_window_3x3 #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int DW    = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  gray_window_3x3_if.slave  win
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x_cnt, pos_x, nxt_x;
  logic [YW-1:0] y_cnt, pos_y, nxt_y;
  logic          accept;
  logic          emit;
  logic          last_px;

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb0_rd, lb1_rd;

  logic [DW-1:0] w [3][3];

  logic          out_valid_q, out_eof_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  assign accept = win.in_valid;

  // SOF overrides the counters so a new frame always starts at (0,0)
  always_comb begin
    pos_x = x_cnt;
    pos_y = y_cnt;
    if (win.in_sof) begin
      pos_x = '0;
      pos_y = '0;
    end
  end

  always_comb begin
    nxt_x = pos_x + XW'(1);
    nxt_y = pos_y;
    if (pos_x == X_LAST) begin
      nxt_x = '0;
      nxt_y = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
    end
  end

  assign last_px = (pos_x == X_LAST) && (pos_y == Y_LAST);
  assign emit    = accept && (pos_x >= XW'(2)) && (pos_y >= YW'(2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      x_cnt <= nxt_x;
      y_cnt <= nxt_y;
    end
  end

  assign lb0_rd = lb0[pos_x];
  assign lb1_rd = lb1[pos_x];

  // Line buffers are plain storage; stale rows are masked by the x>=2, y>=2 rule
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[pos_x] <= lb0_rd;
      lb0[pos_x] <= win.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          w[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        w[r][0] <= w[r][1];
        w[r][1] <= w[r][2];
      end
      w[0][2] <= lb1_rd;
      w[1][2] <= lb0_rd;
      w[2][2] <= win.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      out_valid_q <= emit;
      out_eof_q   <= emit && last_px;
      if (emit) begin
        out_x_q <= pos_x - XW'(1);
        out_y_q <= pos_y - YW'(1);
      end
    end
  end

  assign win.out_valid = out_valid_q;
  assign win.out_eof   = out_eof_q;
  assign win.out_x     = out_x_q;
  assign win.out_y     = out_y_q;

  assign win.data00_o = w[0][0];
  assign win.data01_o = w[0][1];
  assign win.data02_o = w[0][2];
  assign win.data10_o = w[1][0];
  assign win.data11_o = w[1][1];
  assign win.data12_o = w[1][2];
  assign win.data20_o = w[2][0];
  assign win.data21_o = w[2][1];
  assign win.data22_o = w[2][2];
endmodule

// File: tb/tb_gray_window_3x3.sv
// Self-checking bench for gray_window_3x3: image-array reference model compared every
// cycle, plus literal expectations for the first/last windows of each scenario.
module tb_gray_window_3x3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gray_window_3x3_if #(.IMG_W(W), .IMG_H(H), .DW(DW)) bus ();
  gray_window_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .win     (bus)
  );

  logic [DW-1:0] dw [3][3];
  assign dw[0][0] = bus.data00_o;
  assign dw[0][1] = bus.data01_o;
  assign dw[0][2] = bus.data02_o;
  assign dw[1][0] = bus.data10_o;
  assign dw[1][1] = bus.data11_o;
  assign dw[1][2] = bus.data12_o;
  assign dw[2][0] = bus.data20_o;
  assign dw[2][1] = bus.data21_o;
  assign dw[2][2] = bus.data22_o;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // reference model: the current frame as an image, indexed by raster position
  logic [DW-1:0] img [H][W];
  int            mx = 0, my = 0;
  bit            exp_valid = 0, exp_eof = 0;
  int            exp_x = 0, exp_y = 0;
  logic [DW-1:0] exp_w [3][3];

  // observations of DUT windows for the literal checks
  int            win_cnt = 0;
  int            n_eof = 0;
  int            frame_cnts [$];
  logic [31:0]   seq [$];
  logic [31:0]   seq_a [$];
  logic [DW-1:0] first_d00, first_d02, first_d11, first_d20, first_d22, last_d22;
  int            first_x, first_y, last_x, last_y;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_eof", 32'(bus.out_eof), 0);
      chk("rst_x", 32'(bus.out_x), 0);
      chk("rst_y", 32'(bus.out_y), 0);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          chk($sformatf("rst_data%0d%0d", r, c), 32'(dw[r][c]), 0);
      mx = 0; my = 0; exp_valid = 0; exp_eof = 0;
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("out_eof", 32'(bus.out_eof), 32'(exp_eof));
      if (exp_valid) begin
        chk("out_x", 32'(bus.out_x), exp_x);
        chk("out_y", 32'(bus.out_y), exp_y);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            chk($sformatf("data%0d%0d", r, c), 32'(dw[r][c]), 32'(exp_w[r][c]));
      end
      if (bus.out_valid === 1'b1) begin
        if (win_cnt == 0) begin
          first_d00 = dw[0][0]; first_d02 = dw[0][2]; first_d11 = dw[1][1];
          first_d20 = dw[2][0]; first_d22 = dw[2][2];
          first_x = int'(bus.out_x); first_y = int'(bus.out_y);
        end
        win_cnt++;
        seq.push_back({4'(bus.out_x), 4'(bus.out_y), dw[0][0], dw[2][2]});
        if (bus.out_eof === 1'b1) begin
          frame_cnts.push_back(win_cnt);
          last_x = int'(bus.out_x); last_y = int'(bus.out_y); last_d22 = dw[2][2];
          win_cnt = 0;
          n_eof++;
        end
      end
      exp_valid = 0;
      exp_eof = 0;
      if (bus.in_valid === 1'b1) begin
        if (bus.in_sof === 1'b1) begin mx = 0; my = 0; end
        img[my][mx] = bus.in_data;
        if (mx >= 2 && my >= 2) begin
          exp_valid = 1;
          exp_x = mx - 1;
          exp_y = my - 1;
          exp_eof = (mx == W - 1) && (my == H - 1);
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              exp_w[r][c] = img[my - 2 + r][mx - 2 + c];
        end
        mx++;
        if (mx == W) begin
          mx = 0;
          my++;
          if (my == H) my = 0;
        end
      end
    end
  end

  // every task starts and ends 2 time units after a rising edge
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_px(input logic [DW-1:0] d, input bit sof, input bit gap);
    if (gap) begin
      while ($urandom_range(0, 99) >= 40) begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'($urandom_range(0, 1));
        bus.in_data  = DW'($urandom);
        @(posedge clk); #2;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_data  = d;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int x, input int y);
    return DW'(base + y * 16 + x);
  endfunction

  // sends raster positions [from, to) of a frame; the first pixel carries SOF if asked
  task automatic send_range(input int base, input bit sof, input bit gap, input int from, input int to);
    for (int i = from; i < to; i++)
      send_px(pix(base, i % W, i / W), sof && (i == 0), gap);
  endtask

  task automatic phase_start();
    win_cnt = 0;
    n_eof = 0;
    frame_cnts.delete();
    seq.delete();
  endtask

  task automatic chk_count(input string name, input int idx);
    chk(name, (frame_cnts.size() > idx) ? frame_cnts[idx] : -1, 24);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    idle(2);

    // continuous frame
    phase_start();
    send_range(0, 1, 0, 0, W * H);
    idle(3);
    chk("a_first_d00", 32'(first_d00), 32'h000);
    chk("a_first_d02", 32'(first_d02), 32'h002);
    chk("a_first_d11", 32'(first_d11), 32'h011);
    chk("a_first_d20", 32'(first_d20), 32'h020);
    chk("a_first_d22", 32'(first_d22), 32'h022);
    chk("a_first_x", first_x, 1);
    chk("a_first_y", first_y, 1);
    chk_count("a_count", 0);
    chk("a_eofs", n_eof, 1);
    chk("a_last_x", last_x, 6);
    chk("a_last_y", last_y, 4);
    chk("a_last_d22", 32'(last_d22), 32'h057);
    seq_a = seq;

    // gapped frame, random idle data/SOF
    phase_start();
    send_range(0, 1, 1, 0, W * H);
    idle(3);
    chk_count("b_count", 0);
    chk("b_eofs", n_eof, 1);
    chk("b_seq_len", seq.size(), seq_a.size());
    for (int i = 0; i < seq.size() && i < seq_a.size(); i++)
      chk($sformatf("b_seq%0d", i), seq[i], seq_a[i]);

    // back-to-back frames
    phase_start();
    send_range(0, 1, 0, 0, W * H);
    send_range(32'h100, 1, 0, 0, W * H);
    idle(3);
    chk_count("c_count0", 0);
    chk_count("c_count1", 1);
    chk("c_first_d00", 32'(first_d00), 32'h100);
    chk("c_first_d22", 32'(first_d22), 32'h122);
    chk("c_last_d22", 32'(last_d22), 32'h157);

    // SOF at pixel (3,3) restarts with a fresh pattern
    phase_start();
    send_range(0, 1, 0, 0, 3 * W + 3);
    send_px(pix(32'h200, 0, 0), 1, 0);
    win_cnt = 0;
    send_range(32'h200, 0, 0, 1, W * H);
    idle(3);
    chk_count("d_count", 0);
    chk("d_eofs", n_eof, 1);
    chk("d_first_x", first_x, 1);
    chk("d_first_y", first_y, 1);
    chk("d_first_d00", 32'(first_d00), 32'h200);
    chk("d_first_d22", 32'(first_d22), 32'h222);

    // reset for 2 cycles at pixel (4,3), then a frame without SOF
    phase_start();
    send_range(0, 1, 0, 0, 3 * W + 4);
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    idle(2);
    reset_n = 1'b1;
    win_cnt = 0;
    send_range(32'h300, 0, 0, 0, W * H);
    idle(3);
    chk_count("e_count", 0);
    chk("e_first_x", first_x, 1);
    chk("e_first_y", first_y, 1);
    chk("e_first_d00", 32'(first_d00), 32'h300);
    chk("e_last_d22", 32'(last_d22), 32'h357);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gray_window_3x3.md
# gray_window_3x3

Streaming 3x3 neighbourhood generator that sits directly downstream of the grayscale filter. It accepts one 12-bit gray pixel per valid cycle in raster order and stores the two previous image rows in line buffers. For every pixel position where a full 3x3 neighbourhood exists, it emits the nine pixels of that window plus the centre coordinate. Kernel stages (edge/motion detection) consume the window outputs.

## Interface
- IMG_W, 320: pixels per line (>= 3)
- IMG_H, 240: lines per frame (>= 3)
- DW, 12: pixel width; gray format {g,g,g}, passed through untouched
- clk  in  1  pixel clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel accepted this cycle when high; no backpressure
- in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a frame
- in_data  in  DW  gray pixel from the grayscale filter
- out_valid  out  1  window outputs valid this cycle (1-cycle pulse per window)
- out_eof  out  1  high together with out_valid on the last window of a frame
- data00_o … data22_o  out  DW each (9 ports)  window pixels; dataRC_o is row R (0 = oldest line), column C (0 = leftmost)
- out_x  out  $clog2(IMG_W)  x of window centre
- out_y  out  $clog2(IMG_H)  y of window centre

## Operation
- Counters: x_cnt 0..IMG_W-1 and y_cnt 0..IMG_H-1 give the position of the pixel being accepted.
  - After each accepted pixel, x_cnt increments. At IMG_W-1 it wraps to 0 and y_cnt increments. At (IMG_W-1, IMG_H-1) both wrap to 0.
  - An accepted pixel with in_sof=1 is position (0,0), whatever the counter state. Counters continue from (1,0).
- Line buffers: lb0 holds row y-1 and lb1 holds row y-2, each IMG_W x DW.
  - On accept at x: read lb0[x] and lb1[x] (old contents, combinational read).
  - Then write lb1[x] <= lb0[x] and lb0[x] <= in_data.
  - Not cleared by reset.
- Window registers w[r][c], r,c in 0..2. On accept, every row shifts left (w[r][0]<=w[r][1], w[r][1]<=w[r][2]), and the new column 2 loads:
  - w[0][2] <= lb1[x]
  - w[1][2] <= lb0[x]
  - w[2][2] <= in_data
- dataRC_o is driven directly from w[R][C].
- Emission: an accept at (x,y) with x>=2 and y>=2 makes out_valid=1 on the next cycle.
  - out_x = x-1 and out_y = y-1 (the window centre).
  - out_eof = 1 iff (x,y) = (IMG_W-1, IMG_H-1).
- Border centres are never emitted: x=0, x=IMG_W-1, y=0, y=IMG_H-1. Each frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
- Cycles with in_valid=0:
  - Nothing shifts, counters hold, out_valid=0.
  - Data outputs hold their last value.
- Frame bookkeeping:
  - Stale line-buffer and window contents from a previous frame never reach a valid output, because of the x>=2, y>=2 rule.
  - No frame counter and no per-frame state beyond x_cnt/y_cnt.

## Timing
- Reset values:
  - out_valid=0, out_eof=0
  - all dataRC_o=0, out_x=0, out_y=0
  - x_cnt=0, y_cnt=0, all window registers 0
- Latency: 1 clock from the accepting edge of pixel (x,y) to the out_valid cycle of the window centred at (x-1,y-1).
- Throughput: one window per clock sustained with back-to-back in_valid.
- out_valid, out_eof, out_x, out_y and the data ports are all registered and change only on clk edges.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronously).
  - After release, the first accepted pixel is treated as (0,0) even without in_sof.
- in_sof mid-frame restarts the counters. No window is emitted until the new frame reaches (2,2).
- in_sof with in_valid=0 is ignored.

## Test plan
- Frame pattern: IMG_W=8, IMG_H=6, DW=12, in_data = {y,x} (y in bits 7:4, x in bits 3:0), continuous valid, in_sof on the first pixel.
  - First out_valid comes one cycle after pixel (2,2) is accepted.
  - Window values: data00_o=0x000, data02_o=0x002, data11_o=0x011, data20_o=0x020, data22_o=0x022.
  - Centre: out_x=1, out_y=1.
- Count and eof: the same frame gives exactly 24 out_valid pulses.
  - The last pulse has out_eof=1, out_x=6, out_y=4 and data22_o=0x057.
  - out_eof is never high otherwise.
- Gapped input: random in_valid duty (~40%) with the same frame.
  - The sequence of (out_x, out_y, data) matches the continuous-valid run exactly.
  - out_valid is never high on two consecutive cycles without an intervening accept.
- Back-to-back frames: a second frame with data {y,x}+0x100 follows immediately.
  - The first window of frame 2 has data00_o=0x100, with no stale frame-1 pixels.
  - 24 windows are emitted per frame.
- SOF mid-frame: assert in_sof at pixel (3,3) of frame 1 and continue with a fresh pattern.
  - No window is emitted until the restarted frame's (2,2).
  - The windows that follow carry only new-frame values.
- Reset mid-frame: drop reset_n for 2 cycles at pixel (4,3).
  - All outputs read 0 during reset.
  - After release, a fresh frame without in_sof gives its first window at its (2,2) with data00_o = new (0,0) value.
